rom_region_loader: RTL and testbench

Parametrised download router for the ROM/PROM store. It takes the HPS ioctl download stream, decodes each byte into one of `NUM_REGIONS` contiguous address regions using a parameter boundary table, and drives the matching on-chip ROM port with a region-local address. It also tracks per-region completion, out-of-range writes and a running checksum, and emits a done pulse at the end of each download. It sits between the ioctl interface and the per-ROM `dpram_dc` write ports, replacing the fixed-map combinational selector.

---
 rtl/rom_region_loader.sv | 162 ++++++++++++++++
 tb/tb_rom_region_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_region_loader.sv
// rtl/rom_region_loader.sv - ioctl download router into NUM_REGIONS on-chip ROM regions
//
// Decodes each downloaded byte into one of NUM_REGIONS contiguous address
// regions (region i spans [END[i-1], END[i]), region 0 starts at 0) and
// forwards it as a registered write with a region-local address. Tracks
// per-region completion, out-of-range writes and a running byte checksum,
// and pulses DONE once a download has ended.
//
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   DL_ACTIVE         download in progress
//   DL_WR             one-cycle byte strobe
//   DL_ADDR, DL_DATA  global byte address and byte data
//   WR, WR_CS         registered write strobe and one-hot region select
//   WR_ADDR, WR_DATA  region-local offset and data of the write
//   LOADED            sticky per-region "last byte written" flags
//   COMPLETE          all regions loaded (one cycle behind LOADED)
//   ERR               sticky out-of-range write flag
//   CHECKSUM          wrapping sum of accepted in-range bytes
//   BUSY              download or flush in progress
//   DONE              one-cycle pulse at the end of a download

module rom_region_loader #(
  parameter int NUM_REGIONS = 15,
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 8,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_END = {
    25'h17220, 25'h17200, 25'h17100, 25'h17000, 25'h16000,
    25'h14000, 25'h12000, 25'h10000, 25'h0E000, 25'h0C000,
    25'h0A000, 25'h08000, 25'h06000, 25'h04000, 25'h02000
  }
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   DL_ACTIVE,
  input  logic                   DL_WR,
  input  logic [ADDR_W-1:0]      DL_ADDR,
  input  logic [DATA_W-1:0]      DL_DATA,
  output logic                   WR,
  output logic [NUM_REGIONS-1:0] WR_CS,
  output logic [ADDR_W-1:0]      WR_ADDR,
  output logic [DATA_W-1:0]      WR_DATA,
  output logic [NUM_REGIONS-1:0] LOADED,
  output logic                   COMPLETE,
  output logic                   ERR,
  output logic [DATA_W-1:0]      CHECKSUM,
  output logic                   BUSY,
  output logic                   DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0]      region_base [NUM_REGIONS];
  logic [ADDR_W-1:0]      region_end  [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] last_hit;
  logic [ADDR_W-1:0]      sel_base;
  logic                   in_range;
  logic                   accept;
  logic                   start;
  logic                   wr_nxt;
  logic [NUM_REGIONS-1:0] loaded_nxt;
  logic                   err_nxt;
  logic [DATA_W-1:0]      checksum_nxt;

  // Regions are disjoint, so each comparator pair is independent and at most
  // one hit bit is ever set.
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_map
    assign region_end[g] = REGION_END[g*ADDR_W +: ADDR_W];
    if (g == 0) begin : g_first
      assign region_base[g] = '0;
    end else begin : g_rest
      assign region_base[g] = REGION_END[(g-1)*ADDR_W +: ADDR_W];
    end
    assign hit[g]      = (DL_ADDR >= region_base[g]) && (DL_ADDR < region_end[g]);
    assign last_hit[g] = (DL_ADDR == region_end[g] - ADDR_W'(1));
  end

  // One-hot hit makes an OR of masked bases equal to the selected base.
  always_comb begin
    sel_base = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (hit[i]) sel_base = sel_base | region_base[i];
    end
  end

  assign in_range = |hit;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (DL_ACTIVE) begin
          state_nxt = LOAD;
          start     = 1'b1;
          accept    = DL_WR;
        end
      end
      LOAD: begin
        if (!DL_ACTIVE) state_nxt = FLUSH;
        else            accept    = DL_WR;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status starts from zero on the download-start edge; a byte accepted on
  // that same edge is applied on top of the cleared values.
  always_comb begin
    wr_nxt       = accept && in_range;
    loaded_nxt   = (start ? '0 : LOADED) | (accept ? last_hit : '0);
    err_nxt      = (start ? 1'b0 : ERR) | (accept && !in_range);
    checksum_nxt = (start ? '0 : CHECKSUM) + (wr_nxt ? DL_DATA : '0);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      WR       <= 1'b0;
      WR_CS    <= '0;
      WR_ADDR  <= '0;
      WR_DATA  <= '0;
      LOADED   <= '0;
      COMPLETE <= 1'b0;
      ERR      <= 1'b0;
      CHECKSUM <= '0;
      DONE     <= 1'b0;
    end else begin
      WR       <= wr_nxt;
      WR_CS    <= wr_nxt ? hit : '0;
      if (wr_nxt) begin
        WR_ADDR <= DL_ADDR - sel_base;
        WR_DATA <= DL_DATA;
      end
      LOADED   <= loaded_nxt;
      COMPLETE <= start ? 1'b0 : &LOADED;
      ERR      <= err_nxt;
      CHECKSUM <= checksum_nxt;
      DONE     <= (state == FLUSH);
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_rom_region_loader.sv
// tb/tb_rom_region_loader.sv - scoreboard bench for rom_region_loader with a reference model
//
// The DUT uses the default region shape scaled down by 16 so that full-image
// streams stay short.

module tb_rom_region_loader;

  localparam int NR = 15;
  localparam int AW = 25;
  localparam int DW = 8;
  localparam int unsigned ENDS [NR] = '{
    'h200, 'h400, 'h600, 'h800, 'hA00, 'hC00, 'hE00, 'h1000,
    'h1200, 'h1400, 'h1600, 'h1700, 'h1710, 'h1720, 'h1722
  };
  localparam logic [NR*AW-1:0] TB_END = {
    25'h1722, 25'h1720, 25'h1710, 25'h1700, 25'h1600,
    25'h1400, 25'h1200, 25'h1000, 25'h0E00, 25'h0C00,
    25'h0A00, 25'h0800, 25'h0600, 25'h0400, 25'h0200
  };

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          DL_ACTIVE, DL_WR;
  logic [AW-1:0] DL_ADDR;
  logic [DW-1:0] DL_DATA;
  logic          WR;
  logic [NR-1:0] WR_CS;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic [NR-1:0] LOADED;
  logic          COMPLETE, ERR, BUSY, DONE;
  logic [DW-1:0] CHECKSUM;

  rom_region_loader #(
    .NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW), .REGION_END(TB_END)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DL_ACTIVE(DL_ACTIVE), .DL_WR(DL_WR),
    .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA), .WR(WR), .WR_CS(WR_CS),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .LOADED(LOADED),
    .COMPLETE(COMPLETE), .ERR(ERR), .CHECKSUM(CHECKSUM), .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: download session bookkeeping and expected writes.
  typedef struct {
    logic [NR-1:0] cs;
    logic [AW-1:0] off;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb [$];
  exp_t          got;
  logic [NR-1:0] m_loaded;
  logic          m_err;
  logic [DW-1:0] m_sum;
  bit            m_session;
  int            m_done_exp;

  function automatic int unsigned base_of(int r);
    return (r == 0) ? 0 : ENDS[r-1];
  endfunction

  function automatic int region_of(int unsigned a);
    for (int i = 0; i < NR; i++) begin
      if (a >= base_of(i) && a < ENDS[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_loaded  = '0;
    m_err     = 1'b0;
    m_sum     = '0;
    m_session = 0;
    sb.delete();
  endtask

  task automatic model_step(bit act, bit wr, int unsigned a, logic [DW-1:0] d);
    int   r;
    exp_t e;
    if (act && !m_session) begin
      m_session = 1;
      m_loaded  = '0;
      m_err     = 1'b0;
      m_sum     = '0;
    end else if (!act && m_session) begin
      m_session = 0;
      m_done_exp++;
    end
    if (act && wr) begin
      r = region_of(a);
      if (r >= 0) begin
        e.cs   = NR'(1) << r;
        e.off  = AW'(a - base_of(r));
        e.data = d;
        sb.push_back(e);
        m_sum = m_sum + d;
        if (a == ENDS[r] - 1) m_loaded[r] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic cyc(bit act, bit wr, int unsigned a, logic [DW-1:0] d);
    @(posedge CLK); #1;
    DL_ACTIVE = act;
    DL_WR     = wr;
    DL_ADDR   = AW'(a);
    DL_DATA   = d;
    model_step(act, wr, a, d);
  endtask

  // Idle one cycle, then compare status once COMPLETE has caught up.
  task automatic settle(string tag, bit act);
    cyc(act, 0, 0, 8'h00);
    @(negedge CLK);
    @(negedge CLK);
    check({tag, "_loaded"},   32'(LOADED),   32'(m_loaded));
    check({tag, "_err"},      32'(ERR),      32'(m_err));
    check({tag, "_checksum"}, 32'(CHECKSUM), 32'(m_sum));
    check({tag, "_complete"}, 32'(COMPLETE), 32'(m_loaded == {NR{1'b1}}));
  endtask

  task automatic end_download(string tag);
    cyc(0, 0, 0, 8'h00);
    @(negedge CLK);
    @(negedge CLK);
    check({tag, "_busy_flush"}, 32'(BUSY), 32'(1));
    check({tag, "_done_early"}, 32'(DONE), 32'(0));
    @(negedge CLK);
    check({tag, "_done"},       32'(DONE), 32'(1));
    check({tag, "_busy_idle"},  32'(BUSY), 32'(0));
    @(negedge CLK);
    check({tag, "_done_end"},   32'(DONE), 32'(0));
  endtask

  task automatic check_zero(string tag);
    check({tag, "_wr"},       32'(WR),       32'(0));
    check({tag, "_wr_cs"},    32'(WR_CS),    32'(0));
    check({tag, "_wr_addr"},  32'(WR_ADDR),  32'(0));
    check({tag, "_wr_data"},  32'(WR_DATA),  32'(0));
    check({tag, "_loaded"},   32'(LOADED),   32'(0));
    check({tag, "_complete"}, 32'(COMPLETE), 32'(0));
    check({tag, "_err"},      32'(ERR),      32'(0));
    check({tag, "_checksum"}, 32'(CHECKSUM), 32'(0));
    check({tag, "_busy"},     32'(BUSY),     32'(0));
    check({tag, "_done"},     32'(DONE),     32'(0));
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge CLK) begin
    if (WR) begin
      if (sb.size() == 0) begin
        check("wr_unexpected", 32'(1), 32'(0));
      end else begin
        got = sb.pop_front();
        check("wr_cs",   32'(WR_CS),   32'(got.cs));
        check("wr_addr", 32'(WR_ADDR), 32'(got.off));
        check("wr_data", 32'(WR_DATA), 32'(got.data));
      end
    end else begin
      check("wr_cs_idle", 32'(WR_CS), 32'(0));
    end
    if (DONE) begin
      n_done++;
      check("done_after_last_wr", 32'(sb.size()), 32'(0));
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned a;
    m_done_exp = 0;
    model_reset();
    RESET_N   = 1'b0;
    DL_ACTIVE = 1'b0;
    DL_WR     = 1'b0;
    DL_ADDR   = '0;
    DL_DATA   = '0;
    #12;
    check_zero("reset");
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    // First-byte routing.
    cyc(1, 1, 'h0, 8'hA5);
    settle("first", 1);

    // Last byte of region 11.
    cyc(1, 1, 'h16FF, 8'h3C);
    settle("r11_last", 1);
    check("r11_loaded_bit", 32'(LOADED[11]), 32'(1));

    // Out-of-range write.
    cyc(1, 1, 'h1722, 8'h55);
    settle("oor", 1);
    end_download("dl1");

    // Full image, clean.
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 'h1722; i++) cyc(1, 1, i, 8'(i));
    settle("full", 1);
    check("full_all_loaded", 32'(LOADED), 32'h7FFF);
    end_download("full");

    // Strobes without DL_ACTIVE are ignored and status holds.
    for (int i = 0; i < 6; i++) cyc(0, 1, $urandom_range(0, 'h1730), 8'($urandom));
    settle("ignored", 0);

    // Restart with a byte on the same cycle DL_ACTIVE rises.
    cyc(1, 1, 'h1720, 8'h11);
    settle("restart", 1);
    end_download("restart");

    // Full image with reset pulsed mid-stream.
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 'h1722; i++) begin
      if (i == 'h900) begin
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        DL_WR   = 1'b0;
        model_reset();
        #1;
        check_zero("midrst");
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_zero("midrst_hold");
        @(posedge CLK); #1;
        RESET_N = 1'b1;
      end
      cyc(1, 1, i, 8'(i));
    end
    settle("rststream", 1);
    check("rststream_low_regions", 32'(LOADED[3:0]), 32'(0));
    end_download("rststream");

    // Randomized download with repeats, gaps and out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 'h1730);
      cyc(1, 1'($urandom_range(0, 3) != 0), a, 8'($urandom));
    end
    settle("random", 1);
    end_download("random");

    repeat (3) @(negedge CLK);
    check("sb_drained", 32'(sb.size()), 32'(0));
    check("done_count", 32'(n_done), 32'(m_done_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
